mc_ctrl_fsm: RTL and testbench

// Multi-cycle sequencer for the single-issue LoongArch core. Owns the PC register and steps each

---
 rtl/mc_ctrl_fsm.sv | 129 ++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the single-issue LoongArch core.
// Owns the PC, memory handshakes, write-enable pulses and the retired-instruction count.
module mc_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             rf_we_dec,
  input  logic [8:0]       br_type,
  input  logic             jump_en,
  input  logic [31:0]      jump_target,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             idle,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [31:0]      pc_reg;
  logic [31:0]      tgt_reg;
  logic             taken_reg;
  logic             err_reg;
  logic [CNT_W-1:0] retired_reg;

  logic taken_now;
  logic misaligned;

  // A branch counts only when the decoder classified it; jump_en alone is ignored.
  assign taken_now  = jump_en & (|br_type);
  assign misaligned = taken_now & (jump_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (!halt) state_next = S_IF;
      S_IF:   if (imem_ack) state_next = S_ID;
      S_ID:   state_next = S_EX;
      S_EX: begin
        if (misaligned)            state_next = S_ERR;
        else if (is_load | is_store) state_next = S_MEM;
        else                       state_next = S_WB;
      end
      S_MEM:  if (dmem_ack) state_next = S_WB;
      S_WB:   state_next = halt ? S_IDLE : S_IF;
      S_ERR:  state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    idle     = 1'b0;
    case (state_reg)
      S_IF: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
      end
      S_WB:    rf_we = rf_we_dec;
      S_IDLE:  idle  = 1'b1;
      default: ;
    endcase
  end

  // Branch outcome is captured in EX so WB does not depend on BR holding its outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      tgt_reg     <= '0;
      taken_reg   <= 1'b0;
      retired_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (state_reg == S_EX) begin
        taken_reg <= taken_now;
        tgt_reg   <= jump_target;
      end
      if (state_reg == S_WB) begin
        pc_reg      <= taken_reg ? tgt_reg : pc_reg + 32'd4;
        retired_reg <= retired_reg + CNT_W'(1);
      end
      if (state_next == S_ERR) err_reg <= 1'b1;
    end
  end

  assign pc      = pc_reg;
  assign state   = state_reg;
  assign err     = err_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instruction table, hand-written corner sequences,
// then random instructions checked against a per-instruction outcome model.
module tb_mc_ctrl_fsm;

  localparam logic [31:0] RPC = 32'h1C00_0000;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        imem_ack;
  logic        dmem_ack;
  logic        is_load;
  logic        is_store;
  logic        rf_we_dec;
  logic [8:0]  br_type;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic [2:0]  state;
  logic        idle;
  logic        err;
  logic [31:0] retired;

  mc_ctrl_fsm #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .halt(halt), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .is_load(is_load), .is_store(is_store), .rf_we_dec(rf_we_dec), .br_type(br_type),
    .jump_en(jump_en), .jump_target(jump_target), .pc(pc), .imem_req(imem_req),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
    .state(state), .idle(idle), .err(err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_tx     = 0;
  logic [31:0] model_pc;
  int          model_ret;

  // kind: 0 = plain/branch, 1 = load, 2 = store; e_* are the expected outcomes
  typedef struct {
    int          fw;
    int          kind;
    bit          je;
    logic [8:0]  bt;
    logic [31:0] tgt;
    bit          rfd;
    int          mw;
    bit          hv;
    int          e_cyc;
    int          e_dmem;
    int          e_rf;
    logic [31:0] e_pc;
    logic [2:0]  e_state;
    int          e_ret;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Outcome of one instruction from the sequencing rules, independent of encoding.
  function automatic vec_t predict(vec_t v, logic [31:0] pc0, int ret0);
    vec_t r;
    bit   taken;
    bit   bad;
    bit   mem;
    r     = v;
    taken = v.je && (v.bt != 9'd0);
    bad   = taken && (v.tgt[1:0] != 2'b00);
    mem   = (v.kind != 0);
    r.e_cyc   = (v.fw + 1) + 2 + (bad ? 1 : ((mem ? v.mw + 1 : 0) + 1));
    r.e_dmem  = (!bad && mem) ? v.mw + 1 : 0;
    r.e_rf    = (!bad && v.rfd) ? 1 : 0;
    r.e_pc    = bad ? pc0 : (taken ? v.tgt : pc0 + 32'd4);
    r.e_state = bad ? 3'd6 : (v.hv ? 3'd0 : 3'd1);
    r.e_ret   = bad ? ret0 : ret0 + 1;
    return r;
  endfunction

  // Entered and left just after a falling edge with the DUT in IF.
  task automatic apply(input vec_t v);
    int cyc = 0, n_imem = 0, n_dmem = 0, n_dwe = 0, n_ir = 0, n_rf = 0, n_both = 0;
    int fc = 0, mc = 0;
    bit done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      halt        = v.hv;
      is_load     = (v.kind == 1);
      is_store    = (v.kind == 2);
      rf_we_dec   = v.rfd;
      br_type     = v.bt;
      jump_en     = v.je;
      jump_target = v.tgt;
      if (state == 3'd1) imem_ack = (fc == v.fw);
      else               imem_ack = 1'($urandom_range(0, 1));
      if (state == 3'd4) dmem_ack = (mc == v.mw);
      else               dmem_ack = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (imem_req) n_imem++;
      if (dmem_req) n_dmem++;
      if (dmem_we)  n_dwe++;
      if (ir_we)    n_ir++;
      if (rf_we)    n_rf++;
      if (imem_req && dmem_req) n_both++;
      if (state == 3'd1) fc++;
      if (state == 3'd4) mc++;
      if (state == 3'd5 || state == 3'd6) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("instr_done", 32'(done), 32'd1);
    chk("cycles", cyc, v.e_cyc);
    chk("imem_req_cycles", n_imem, v.fw + 1);
    chk("ir_we_pulses", n_ir, 1);
    chk("dmem_req_cycles", n_dmem, v.e_dmem);
    chk("dmem_we_cycles", n_dwe, (v.kind == 2) ? v.e_dmem : 0);
    chk("rf_we_pulses", n_rf, v.e_rf);
    chk("req_overlap", n_both, 0);
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("end_state", 32'(state), 32'(v.e_state));
    chk("pc", pc, v.e_pc);
    chk("retired", retired, v.e_ret);
    chk("err", 32'(err), 32'(v.e_state == 3'd6));
    chk("idle", 32'(idle), 32'(v.e_state == 3'd0));
    $display("tx %0d kind=%0d fw=%0d mw=%0d pc=%h state=%0d retired=%0d",
             n_tx, v.kind, v.fw, v.mw, pc, state, retired);
    n_tx++;
  endtask

  // Parked in IDLE: hold halt, then release and expect a fetch at the unchanged pc.
  task automatic idle_release(input int hold, input logic [31:0] exp_pc);
    for (int h = 0; h < hold; h++) begin
      halt     = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      chk("idle_hold", 32'({idle, imem_req, dmem_req, state}), 32'({1'b1, 1'b0, 1'b0, 3'd0}));
    end
    halt     = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_exit_state", 32'(state), 32'd1);
    chk("idle_exit_pc", pc, exp_pc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; is_load = 1'b0; is_store = 1'b0;
    rf_we_dec = 1'b0; br_type = '0; jump_en = 1'b0; jump_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_pc", pc, RPC);
    chk("rst_retired", retired, 32'd0);
    chk("rst_flags", 32'({err, idle, ir_we, rf_we, dmem_req}), 32'd0);
    model_pc  = RPC;
    model_ret = 0;
  endtask

  vec_t tbl [9];
  vec_t v;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //        fw kind je bt         tgt           rfd mw hv cyc dmem rf pc            st ret
    tbl[0] = '{0, 0, 0, 9'h000, 32'h0,        1, 0, 0, 4, 0, 1, 32'h1C00_0004, 3'd1, 1};
    tbl[1] = '{0, 0, 1, 9'h002, 32'h1C00_0040, 0, 0, 0, 4, 0, 0, 32'h1C00_0040, 3'd1, 2};
    tbl[2] = '{1, 1, 0, 9'h000, 32'h0,        1, 3, 0, 9, 4, 1, 32'h1C00_0044, 3'd1, 3};
    tbl[3] = '{0, 2, 0, 9'h000, 32'h0,        0, 0, 0, 5, 1, 0, 32'h1C00_0048, 3'd1, 4};
    tbl[4] = '{2, 0, 0, 9'h100, 32'h1C00_0100, 1, 0, 0, 6, 0, 1, 32'h1C00_004C, 3'd1, 5};
    tbl[5] = '{0, 0, 1, 9'h000, 32'h1C00_0200, 1, 0, 0, 4, 0, 1, 32'h1C00_0050, 3'd1, 6};
    tbl[6] = '{0, 0, 1, 9'h080, 32'hFFFF_FFFC, 1, 0, 0, 4, 0, 1, 32'hFFFF_FFFC, 3'd1, 7};
    tbl[7] = '{0, 0, 0, 9'h000, 32'h0,        0, 0, 0, 4, 0, 0, 32'h0000_0000, 3'd1, 8};
    tbl[8] = '{0, 1, 1, 9'h001, 32'h1C00_0042, 1, 0, 0, 4, 0, 0, 32'h0000_0000, 3'd6, 8};

    do_reset();
    for (int i = 0; i < 9; i++) apply(tbl[i]);

    // ERR is sticky and silent whatever the inputs do
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1; halt = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      chk("err_sticky", 32'({err, state}), 32'({1'b1, 3'd6}));
      chk("err_quiet", 32'({imem_req, dmem_req, ir_we, rf_we}), 32'd0);
      chk("err_pc", pc, 32'h0);
    end

    // halt held from fetch onwards still lets the instruction retire, then parks
    do_reset();
    v = '{0, 0, 0, 9'h000, 32'h0, 1, 0, 1, 0, 0, 0, 32'h0, 3'd0, 0};
    v = predict(v, model_pc, model_ret);
    apply(v);
    model_pc = v.e_pc; model_ret = v.e_ret;
    idle_release(3, model_pc);

    // reset in the middle of a load: request dropped, no retirement
    for (int k = 0; k < 20; k++) begin
      is_load = 1'b1; rf_we_dec = 1'b1; dmem_ack = 1'b0;
      imem_ack = (state == 3'd1);
      #1;
      if (state == 3'd4) break;
      @(negedge clk);
    end
    chk("reached_mem", 32'({state, dmem_req}), 32'({3'd4, 1'b1}));
    rst = 1'b1;
    #1;
    chk("async_rst", 32'({state, dmem_req}), 32'({3'd1, 1'b0}));
    @(negedge clk);
    rst = 1'b0; is_load = 1'b0; rf_we_dec = 1'b0;
    #1;
    chk("mem_rst_state", 32'({state, dmem_req, rf_we}), 32'({3'd1, 1'b0, 1'b0}));
    chk("mem_rst_pc", pc, RPC);
    chk("mem_rst_retired", retired, 32'd0);
    model_pc = RPC; model_ret = 0;

    for (int i = 0; i < 40; i++) begin
      logic [8:0] bt;
      bt = ($urandom_range(0, 2) == 0) ? 9'd0 : (9'd1 << $urandom_range(0, 8));
      v.fw   = $urandom_range(0, 3);
      v.kind = $urandom_range(0, 2);
      v.je   = 1'($urandom_range(0, 1));
      v.bt   = bt;
      v.tgt  = {$urandom(), 2'b00} >> 0;
      v.tgt[1:0] = 2'b00;
      v.rfd  = 1'($urandom_range(0, 1));
      v.mw   = $urandom_range(0, 3);
      v.hv   = ($urandom_range(0, 7) == 0);
      v = predict(v, model_pc, model_ret);
      apply(v);
      model_pc = v.e_pc; model_ret = v.e_ret;
      if (v.hv) idle_release($urandom_range(1, 3), model_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
